// File: rtl/retire_perf_monitor.sv
`default_nettype none
// ============================================================================
// Module      : retire_perf_monitor
// Description : Retire-interface performance counters with halt detection,
//               cycle-limit watchdog and a registered counter readout port.
// Revision    : 1.0 - initial release
// ============================================================================
module retire_perf_monitor #(
    parameter int CNT_WIDTH = 32,
    parameter int TIMEOUT   = 40000
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_clear,
    input  logic                 i_retire_valid,
    input  logic                 i_retire_halt,
    input  logic                 i_retire_trap,
    input  logic                 i_retire_dmem_ren,
    input  logic                 i_retire_dmem_wen,
    input  logic [2:0]           i_sel,
    output logic [CNT_WIDTH-1:0] o_count,
    output logic                 o_running,
    output logic                 o_halted,
    output logic                 o_timeout
);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_RUN     = 2'd1;
    localparam logic [1:0] c_ST_HALTED  = 2'd2;
    localparam logic [1:0] c_ST_TIMEOUT = 2'd3;

    localparam int                   c_NUM_CNT = 6;
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] c_TIMEOUT = CNT_WIDTH'(TIMEOUT);
    localparam bit                   c_WDOG_EN = (TIMEOUT != 0);

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [CNT_WIDTH-1:0] r_cnt     [c_NUM_CNT];
    logic [CNT_WIDTH-1:0] w_cnt_nxt [c_NUM_CNT];
    logic [c_NUM_CNT-1:0] w_inc;
    logic                 w_run;
    logic                 w_halt;
    logic                 w_wdog_hit;
    logic [CNT_WIDTH-1:0] w_sel_val;
    logic [CNT_WIDTH-1:0] r_count;
    logic                 r_running;
    logic                 r_halted;
    logic                 r_timeout;

    assign w_run  = (r_state == c_ST_RUN);
    assign w_halt = w_run & i_retire_valid & i_retire_halt;

    // Counter order matches the select encoding: cycles, retired, loads,
    // stores, traps, idle.
    assign w_inc = {w_run & ~i_retire_valid,
                    w_run &  i_retire_valid & i_retire_trap,
                    w_run &  i_retire_valid & i_retire_dmem_wen,
                    w_run &  i_retire_valid & i_retire_dmem_ren,
                    w_run &  i_retire_valid,
                    w_run};

    generate
        for (genvar g = 0; g < c_NUM_CNT; g++) begin : g_cnt_nxt
            assign w_cnt_nxt[g] = (w_inc[g] && (r_cnt[g] != c_CNT_MAX))
                                ? r_cnt[g] + c_CNT_ONE
                                : r_cnt[g];
        end
    endgenerate

    // The watchdog looks at the post-increment cycle count, so the cycle
    // that reaches the limit is itself counted.
    assign w_wdog_hit = c_WDOG_EN && w_run && !w_halt && (w_cnt_nxt[0] == c_TIMEOUT);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (i_start) w_state_nxt = c_ST_RUN;
            end
            c_ST_RUN: begin
                if (w_halt)          w_state_nxt = c_ST_HALTED;
                else if (w_wdog_hit) w_state_nxt = c_ST_TIMEOUT;
            end
            default: w_state_nxt = r_state;
        endcase
    end

    always_comb begin
        w_sel_val = '0;
        case (i_sel)
            3'd6:    w_sel_val = {{(CNT_WIDTH-3){1'b0}}, r_timeout, r_halted, r_running};
            3'd7:    w_sel_val = '0;
            default: w_sel_val = r_cnt[i_sel];
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= c_ST_IDLE;
            r_running <= 1'b0;
            r_halted  <= 1'b0;
            r_timeout <= 1'b0;
            r_count   <= '0;
            for (int i = 0; i < c_NUM_CNT; i++) r_cnt[i] <= '0;
        end else if (i_clear) begin
            r_state   <= c_ST_IDLE;
            r_running <= 1'b0;
            r_halted  <= 1'b0;
            r_timeout <= 1'b0;
            r_count   <= '0;
            for (int i = 0; i < c_NUM_CNT; i++) r_cnt[i] <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_running <= (w_state_nxt == c_ST_RUN);
            r_halted  <= (w_state_nxt == c_ST_HALTED);
            r_timeout <= (w_state_nxt == c_ST_TIMEOUT);
            r_count   <= w_sel_val;
            for (int i = 0; i < c_NUM_CNT; i++) r_cnt[i] <= w_cnt_nxt[i];
        end
    end

    assign o_count   = r_count;
    assign o_running = r_running;
    assign o_halted  = r_halted;
    assign o_timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_retire_perf_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_retire_perf_monitor
// Description : Self-checking bench; two monitor configurations share one
//               stimulus stream and are compared against a counting model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_retire_perf_monitor;

    localparam int c_IDLE    = 0;
    localparam int c_RUN     = 1;
    localparam int c_HALTED  = 2;
    localparam int c_TIMEOUT = 3;

    logic        clk;
    logic        rst_n;
    logic        start, clear, valid, halt, trap, ren, wen;
    logic [2:0]  sel;
    logic [31:0] cnt_a;
    logic [7:0]  cnt_b;
    logic        run_a, hlt_a, to_a, run_b, hlt_b, to_b;

    int     n_checks;
    int     n_fail;
    longint m_cnt [2][6];
    int     m_st  [2];
    longint m_oc  [2];
    longint m_max [2];
    longint m_tmo [2];

    retire_perf_monitor #(.CNT_WIDTH(32), .TIMEOUT(16)) u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_clear(clear),
        .i_retire_valid(valid), .i_retire_halt(halt), .i_retire_trap(trap),
        .i_retire_dmem_ren(ren), .i_retire_dmem_wen(wen), .i_sel(sel),
        .o_count(cnt_a), .o_running(run_a), .o_halted(hlt_a), .o_timeout(to_a)
    );

    retire_perf_monitor #(.CNT_WIDTH(8), .TIMEOUT(0)) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_clear(clear),
        .i_retire_valid(valid), .i_retire_halt(halt), .i_retire_trap(trap),
        .i_retire_dmem_ren(ren), .i_retire_dmem_wen(wen), .i_sel(sel),
        .o_count(cnt_b), .o_running(run_b), .o_halted(hlt_b), .o_timeout(to_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint status_of(input int s);
        return (s == c_TIMEOUT) ? 4 : (s == c_HALTED) ? 2 : (s == c_RUN) ? 1 : 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = c_IDLE;
            m_oc[k] = 0;
            for (int i = 0; i < 6; i++) m_cnt[k][i] = 0;
        end
    endtask

    task automatic bump(input int k, input int i, input bit en);
        if (en && m_cnt[k][i] < m_max[k]) m_cnt[k][i] = m_cnt[k][i] + 1;
    endtask

    // One clock edge of the reference behaviour, using the inputs as sampled.
    task automatic model_step();
        longint ocn;
        for (int k = 0; k < 2; k++) begin
            if (clear) begin
                m_st[k] = c_IDLE;
                m_oc[k] = 0;
                for (int i = 0; i < 6; i++) m_cnt[k][i] = 0;
            end else begin
                ocn = (sel < 3'd6) ? m_cnt[k][sel] : (sel == 3'd6) ? status_of(m_st[k]) : 0;
                if (m_st[k] == c_RUN) begin
                    bump(k, 0, 1'b1);
                    bump(k, 1, valid);
                    bump(k, 2, valid && ren);
                    bump(k, 3, valid && wen);
                    bump(k, 4, valid && trap);
                    bump(k, 5, !valid);
                    if (valid && halt)
                        m_st[k] = c_HALTED;
                    else if (m_tmo[k] != 0 && m_cnt[k][0] == m_tmo[k])
                        m_st[k] = c_TIMEOUT;
                end else if (m_st[k] == c_IDLE && start) begin
                    m_st[k] = c_RUN;
                end
                m_oc[k] = ocn;
            end
        end
    endtask

    task automatic compare_all();
        check("a_count",   {32'b0, cnt_a}, m_oc[0]);
        check("a_running", {63'b0, run_a}, (m_st[0] == c_RUN)     ? 1 : 0);
        check("a_halted",  {63'b0, hlt_a}, (m_st[0] == c_HALTED)  ? 1 : 0);
        check("a_timeout", {63'b0, to_a},  (m_st[0] == c_TIMEOUT) ? 1 : 0);
        check("b_count",   {56'b0, cnt_b}, m_oc[1]);
        check("b_running", {63'b0, run_b}, (m_st[1] == c_RUN)     ? 1 : 0);
        check("b_halted",  {63'b0, hlt_b}, (m_st[1] == c_HALTED)  ? 1 : 0);
        check("b_timeout", {63'b0, to_b},  (m_st[1] == c_TIMEOUT) ? 1 : 0);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_in(input bit s, input bit c, input bit v, input bit h,
                          input bit t, input bit r, input bit w);
        start = s; clear = c; valid = v; halt = h; trap = t; ren = r; wen = w;
    endtask

    task automatic quiet();
        set_in(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_clear();
        set_in(0, 1, 0, 0, 0, 0, 0);
        tick();
        quiet();
    endtask

    task automatic do_start();
        set_in(1, 0, 0, 0, 0, 0, 0);
        tick();
        quiet();
    endtask

    task automatic read_a(input string name, input logic [2:0] s, input longint exp);
        sel = s;
        tick();
        check(name, {32'b0, cnt_a}, exp);
    endtask

    task automatic read_b(input string name, input logic [2:0] s, input longint exp);
        sel = s;
        tick();
        check(name, {56'b0, cnt_b}, exp);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_max[0] = 64'h0000_0000_FFFF_FFFF;
        m_max[1] = 255;
        m_tmo[0] = 16;
        m_tmo[1] = 0;
        model_reset();
        rst_n = 1'b0;
        sel   = 3'd0;
        quiet();
        tick();
        check("reset_count", {32'b0, cnt_a}, 0);
        check("reset_flags", {61'b0, to_a, hlt_a, run_a}, 0);
        rst_n = 1'b1;
        tick();

        // Basic run: valid on even cycles, halt on the 10th.
        do_start();
        check("start_running", {63'b0, run_a}, 1);
        for (int i = 1; i <= 10; i++) begin
            set_in(0, 0, (i % 2) == 0, i == 10, 0, 0, 0);
            tick();
        end
        quiet();
        check("basic_halted",  {63'b0, hlt_a}, 1);
        check("basic_running", {63'b0, run_a}, 0);
        repeat (20) tick();
        read_a("basic_cycles",  3'd0, 10);
        read_a("basic_retired", 3'd1, 5);
        read_a("basic_idle",    3'd5, 5);
        read_a("basic_status",  3'd6, 2);

        // Classification mix over 8 back-to-back retirements.
        do_clear();
        do_start();
        for (int i = 1; i <= 8; i++) begin
            set_in(0, 0, 1, i == 8, i == 6, i <= 3, i == 4 || i == 5);
            tick();
        end
        quiet();
        read_a("mix_loads",   3'd2, 3);
        read_a("mix_stores",  3'd3, 2);
        read_a("mix_traps",   3'd4, 1);
        read_a("mix_retired", 3'd1, 8);
        read_a("mix_idle",    3'd5, 0);
        read_a("mix_cycles",  3'd0, 8);

        // Watchdog expiry and same-cycle halt precedence.
        do_clear();
        do_start();
        repeat (15) tick();
        check("wdog_not_yet", {62'b0, to_a, run_a}, 1);
        tick();
        check("wdog_timeout", {62'b0, to_a, hlt_a}, 2);
        read_a("wdog_cycles", 3'd0, 16);
        do_clear();
        do_start();
        repeat (15) tick();
        set_in(0, 0, 1, 1, 0, 0, 0);
        tick();
        quiet();
        check("wdog_halt_wins", {62'b0, to_a, hlt_a}, 1);
        read_a("wdog_halt_cycles", 3'd0, 16);

        // Saturation on the 8-bit, watchdog-free instance.
        do_clear();
        do_start();
        for (int i = 0; i < 300; i++) begin
            set_in(0, 0, 1, 0, 0, 0, 0);
            tick();
        end
        quiet();
        read_b("sat_cycles",  3'd0, 255);
        read_b("sat_retired", 3'd1, 255);
        check("sat_running", {63'b0, run_b}, 1);

        // Start ignored while halted; clear returns to idle; clear beats start.
        do_clear();
        do_start();
        set_in(0, 0, 1, 1, 0, 0, 0);
        tick();
        set_in(1, 0, 0, 0, 0, 0, 0);
        tick();
        quiet();
        check("ign_halted", {62'b0, hlt_a, run_a}, 2);
        read_a("ign_cycles", 3'd0, 1);
        do_clear();
        for (int s = 0; s < 7; s++) read_a($sformatf("clr_sel%0d", s), 3'(s), 0);
        set_in(1, 1, 0, 0, 0, 0, 0);
        tick();
        quiet();
        check("clr_start_idle", {61'b0, to_a, hlt_a, run_a}, 0);

        // Randomised traffic.
        do_clear();
        for (int i = 0; i < 3000; i++) begin
            set_in(($urandom % 8) == 0, ($urandom % 64) == 0, ($urandom % 2) == 0,
                   ($urandom % 20) == 0, ($urandom % 8) == 0,
                   ($urandom % 3) == 0, ($urandom % 3) == 0);
            sel = 3'($urandom % 8);
            tick();
        end
        quiet();

        // Asynchronous reset between edges, mid-run.
        do_clear();
        do_start();
        for (int i = 0; i < 5; i++) begin
            set_in(0, 0, 1, 0, 0, 1, 0);
            tick();
        end
        quiet();
        sel = 3'd0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_a", {29'b0, cnt_a, to_a, hlt_a, run_a}, 0);
        check("arst_b", {53'b0, cnt_b, to_b, hlt_b, run_b}, 0);
        tick();
        rst_n = 1'b1;
        read_a("arst_status", 3'd6, 0);
        read_a("arst_cycles", 3'd0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
